exec_alu_div: RTL and testbench

- Parametrised successor to the current single-cycle execute stage.
- Takes one decoded integer operation per accepted request and returns register writebacks and PSW flags through explicit ports; it does not own GR, PSW or PC.
- Adds a valid/ready handshake and a multi-cycle signed/unsigned radix-2 divider with a second (remainder) write port.
- Adds a defined divide-by-zero and overflow policy.

---
 rtl/exec_alu_div.sv | 222 ++++++++++++++++++++++
 tb/tb_exec_alu_div.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_alu_div.sv
// rtl/exec_alu_div.sv - integer execute stage with valid/ready handshake and multi-cycle radix-2 divider
module exec_alu_div #(
  parameter int W  = 32,
  parameter int RA = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          cin,
  input  logic [RA-1:0] dst,
  input  logic [RA-1:0] dst2,
  output logic          out_valid,
  output logic          wr_en,
  output logic [RA-1:0] wr_addr,
  output logic [W-1:0]  wr_data,
  output logic          wr2_en,
  output logic [RA-1:0] wr2_addr,
  output logic [W-1:0]  wr2_data,
  output logic [3:0]    flag_we,
  output logic [3:0]    flags
);

  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  typedef enum logic [2:0] {IDLE, ALU_OUT, DIV_RUN, DIV_FIX, DIV_OUT} state_t;

  state_t        state;
  logic          accept;
  logic          is_div;

  // ALU result path
  logic [W:0]    sum_ext;
  logic [W:0]    dif_ext;
  logic [W-1:0]  alu_r;
  logic          alu_cy;
  logic          alu_ov;
  logic [3:0]    alu_we;

  // divider state: quotient shifts in from the bottom while dividend shifts out the top
  logic [W-1:0]  div_q;
  logic [W-1:0]  div_r;
  logic [W-1:0]  divisor;
  logic [CW-1:0] cnt;
  logic          neg_q;
  logic          neg_r;
  logic          div_zero;
  logic          div_ovf;
  logic [RA-1:0] d_dst;
  logic [RA-1:0] d_dst2;

  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic [W:0]    rem_sh;
  logic [W:0]    trial;
  logic [W-1:0]  q_fin;
  logic [W-1:0]  r_fin;

  assign in_ready = (state == IDLE) || (state == ALU_OUT);
  assign accept   = in_valid && in_ready;
  assign is_div   = (op[2:1] == 2'b11);

  assign sum_ext = {1'b0, b} + {1'b0, a} + {{W{1'b0}}, (op == 3'd1) & cin};
  assign dif_ext = {1'b0, b} - {1'b0, a};

  // only DIV (signed) takes magnitudes; DIVU passes operands through
  assign a_mag = ((op == 3'd6) && a[W-1]) ? ({W{1'b0}} - a) : a;
  assign b_mag = ((op == 3'd6) && b[W-1]) ? ({W{1'b0}} - b) : b;

  // restoring step: partial remainder always stays below divisor, so W+1 bits suffice
  assign rem_sh = {div_r, div_q[W-1]};
  assign trial  = rem_sh - {1'b0, divisor};

  assign q_fin = neg_q ? ({W{1'b0}} - div_q) : div_q;
  assign r_fin = neg_r ? ({W{1'b0}} - div_r) : div_r;

  // single-cycle ALU result and flags for ops 0-5
  always_comb begin
    alu_r  = '0;
    alu_cy = 1'b0;
    alu_ov = 1'b0;
    alu_we = 4'b0000;
    case (op)
      3'd0, 3'd1: begin
        alu_r  = sum_ext[W-1:0];
        alu_cy = sum_ext[W];
        alu_ov = (a[W-1] == b[W-1]) && (alu_r[W-1] != a[W-1]);
        alu_we = 4'b1111;
      end
      3'd2: begin
        alu_r  = dif_ext[W-1:0];
        alu_cy = dif_ext[W];
        alu_ov = (a[W-1] != b[W-1]) && (alu_r[W-1] != b[W-1]);
        alu_we = 4'b1111;
      end
      3'd3: begin
        alu_r  = b & a;
        alu_we = 4'b0111;
      end
      3'd4: begin
        alu_r  = b | a;
        alu_we = 4'b0111;
      end
      3'd5: begin
        alu_r  = b ^ a;
        alu_we = 4'b0111;
      end
      default: begin
        alu_r  = '0;
        alu_we = 4'b0000;
      end
    endcase
  end

  // control FSM, divider datapath and registered writeback outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr2_en    <= 1'b0;
      wr2_addr  <= '0;
      wr2_data  <= '0;
      flag_we   <= 4'b0000;
      flags     <= 4'b0000;
      div_q     <= '0;
      div_r     <= '0;
      divisor   <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
      div_ovf   <= 1'b0;
      d_dst     <= '0;
      d_dst2    <= '0;
    end else begin
      out_valid <= 1'b0;
      wr_en     <= 1'b0;
      wr2_en    <= 1'b0;
      flag_we   <= 4'b0000;
      case (state)
        IDLE, ALU_OUT: begin
          if (accept && is_div) begin
            div_q    <= b_mag;
            div_r    <= '0;
            divisor  <= a_mag;
            cnt      <= CW'(W);
            neg_q    <= (op == 3'd6) && (a[W-1] ^ b[W-1]);
            neg_r    <= (op == 3'd6) && b[W-1];
            div_zero <= (a == '0);
            div_ovf  <= (op == 3'd6) && (b == MIN_NEG) && (a == ALL_ONES);
            d_dst    <= dst;
            d_dst2   <= dst2;
            state    <= DIV_RUN;
          end else if (accept) begin
            out_valid <= 1'b1;
            wr_en     <= (dst != '0);
            wr_addr   <= dst;
            wr_data   <= alu_r;
            wr2_addr  <= '0;
            flag_we   <= alu_we;
            flags     <= {alu_cy, alu_ov, alu_r[W-1], (alu_r == '0)};
            state     <= ALU_OUT;
          end else begin
            state <= IDLE;
          end
        end
        DIV_RUN: begin
          if (!trial[W]) begin
            div_r <= trial[W-1:0];
            div_q <= {div_q[W-2:0], 1'b1};
          end else begin
            div_r <= rem_sh[W-1:0];
            div_q <= {div_q[W-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          out_valid <= 1'b1;
          wr_addr   <= d_dst;
          wr2_addr  <= d_dst2;
          if (div_zero) begin
            flag_we <= 4'b0100;
            flags   <= 4'b0100;
          end else if (div_ovf) begin
            wr_en    <= (d_dst != '0);
            wr2_en   <= (d_dst2 != '0) && (d_dst2 != d_dst);
            wr_data  <= MIN_NEG;
            wr2_data <= '0;
            flag_we  <= 4'b0111;
            flags    <= 4'b0110;
          end else begin
            wr_en    <= (d_dst != '0);
            wr2_en   <= (d_dst2 != '0) && (d_dst2 != d_dst);
            wr_data  <= q_fin;
            wr2_data <= r_fin;
            flag_we  <= 4'b0111;
            flags    <= {2'b00, q_fin[W-1], (q_fin == '0)};
          end
          state <= DIV_OUT;
        end
        DIV_OUT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_alu_div.sv
// tb/tb_exec_alu_div.sv - directed self-checking bench for exec_alu_div
module tb_exec_alu_div;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [4:0]  dst;
  logic [4:0]  dst2;
  logic        out_valid;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr2_en;
  logic [4:0]  wr2_addr;
  logic [31:0] wr2_data;
  logic [3:0]  flag_we;
  logic [3:0]  flags;

  int n_assert;
  int n_fail;

  exec_alu_div #(.W(32), .RA(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .cin(cin), .dst(dst), .dst2(dst2),
    .out_valid(out_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr2_en(wr2_en), .wr2_addr(wr2_addr), .wr2_data(wr2_data),
    .flag_we(flag_we), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input logic c, input logic [4:0] d, input logic [4:0] d2);
    op = o; a = aa; b = bb; cin = c; dst = d; dst2 = d2; in_valid = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0;
    drive(3'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({in_ready, out_valid, wr_en, wr2_en} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected %b", {in_ready, out_valid, wr_en, wr2_en}, 4'b1000);
    end
    n_assert++;
    if ({wr_data, wr2_data, wr_addr, wr2_addr, flag_we, flags} !== 82'd0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {wr_data, wr2_data, wr_addr, wr2_addr, flag_we, flags});
    end
  endtask

  task automatic test_add;
    drive(3'd0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 5'd3, 5'd0);
    @(negedge clk);
    in_valid = 1'b0;
    n_assert++;
    if ({out_valid, wr_en, wr2_en, wr_addr} !== {3'b110, 5'd3}) begin
      n_fail++; $display("FAIL add_ctrl: got %b expected %b", {out_valid, wr_en, wr2_en, wr_addr}, {3'b110, 5'd3});
    end
    n_assert++;
    if (wr_data !== 32'h80000000) begin
      n_fail++; $display("FAIL add_data: got %h expected %h", wr_data, 32'h80000000);
    end
    n_assert++;
    if ({flag_we, flags} !== 8'b1111_0110) begin
      n_fail++; $display("FAIL add_flags: got %b expected %b", {flag_we, flags}, 8'b1111_0110);
    end
    @(negedge clk);
    n_assert++;
    if ({out_valid, wr_en, flag_we} !== 6'd0) begin
      n_fail++; $display("FAIL add_pulse: got %b expected %b", {out_valid, wr_en, flag_we}, 6'd0);
    end
    drive(3'd1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 5'd9, 5'd0);
    @(negedge clk);
    in_valid = 1'b0;
    n_assert++;
    if ({wr_data, flag_we, flags} !== {32'h0, 8'b1111_1001}) begin
      n_fail++; $display("FAIL addc: got %h expected %h", {wr_data, flag_we, flags}, {32'h0, 8'b1111_1001});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    drive(3'd2, 32'd5, 32'd3, 1'b0, 5'd4, 5'd0);
    @(negedge clk);
    n_assert++;
    if ({out_valid, wr_en, wr_addr, wr_data} !== {2'b11, 5'd4, 32'hFFFFFFFE}) begin
      n_fail++; $display("FAIL sub_data: got %h expected %h", {out_valid, wr_en, wr_addr, wr_data}, {2'b11, 5'd4, 32'hFFFFFFFE});
    end
    n_assert++;
    if ({flag_we, flags} !== 8'b1111_1010) begin
      n_fail++; $display("FAIL sub_flags: got %b expected %b", {flag_we, flags}, 8'b1111_1010);
    end
    n_assert++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready: got %b expected 1", in_ready);
    end
    drive(3'd3, 32'h000000F0, 32'h0000000F, 1'b0, 5'd1, 5'd0);
    @(negedge clk);
    in_valid = 1'b0;
    n_assert++;
    if ({out_valid, wr_en, wr_addr, wr_data} !== {2'b11, 5'd1, 32'h0}) begin
      n_fail++; $display("FAIL and_data: got %h expected %h", {out_valid, wr_en, wr_addr, wr_data}, {2'b11, 5'd1, 32'h0});
    end
    n_assert++;
    if ({flag_we, flags[2:0]} !== 7'b0111_001) begin
      n_fail++; $display("FAIL and_flags: got %b expected %b", {flag_we, flags[2:0]}, 7'b0111_001);
    end
    @(negedge clk);
  endtask

  task automatic test_div_signed;
    int cyc;
    logic rdy_hi;
    drive(3'd6, 32'hFFFFFFFD, 32'd7, 1'b0, 5'd5, 5'd6);
    @(negedge clk);
    in_valid = 1'b0;
    a = 32'd0; b = 32'd0; dst = 5'd0; dst2 = 5'd0;
    cyc = 1; rdy_hi = 1'b0;
    while (out_valid !== 1'b1 && cyc < 60) begin
      if (in_ready !== 1'b0) rdy_hi = 1'b1;
      @(negedge clk);
      cyc++;
    end
    n_assert++;
    if (cyc !== 34) begin
      n_fail++; $display("FAIL div_latency: got %0d expected %0d", cyc, 34);
    end
    n_assert++;
    if ({rdy_hi, in_ready} !== 2'b00) begin
      n_fail++; $display("FAIL div_ready: got %b expected %b", {rdy_hi, in_ready}, 2'b00);
    end
    n_assert++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd5, 32'hFFFFFFFE}) begin
      n_fail++; $display("FAIL div_quot: got %h expected %h", {wr_en, wr_addr, wr_data}, {1'b1, 5'd5, 32'hFFFFFFFE});
    end
    n_assert++;
    if ({wr2_en, wr2_addr, wr2_data} !== {1'b1, 5'd6, 32'd1}) begin
      n_fail++; $display("FAIL div_rem: got %h expected %h", {wr2_en, wr2_addr, wr2_data}, {1'b1, 5'd6, 32'd1});
    end
    n_assert++;
    if ({flag_we, flags[2:0]} !== 7'b0111_010) begin
      n_fail++; $display("FAIL div_flags: got %b expected %b", {flag_we, flags[2:0]}, 7'b0111_010);
    end
    @(negedge clk);
    drive(3'd6, 32'd2, 32'hFFFFFFF9, 1'b0, 5'd11, 5'd0);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    n_assert++;
    if ({cyc[7:0], wr_en, wr2_en, wr_data, wr2_data} !== {8'd34, 2'b10, 32'hFFFFFFFD, 32'hFFFFFFFF}) begin
      n_fail++; $display("FAIL div_negdvd: got %h expected %h", {cyc[7:0], wr_en, wr2_en, wr_data, wr2_data}, {8'd34, 2'b10, 32'hFFFFFFFD, 32'hFFFFFFFF});
    end
    @(negedge clk);
  endtask

  task automatic test_divu;
    int cyc;
    drive(3'd7, 32'd3, 32'hFFFFFFFF, 1'b0, 5'd9, 5'd9);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    n_assert++;
    if ({cyc[7:0], wr_en, wr2_en, wr_data} !== {8'd34, 2'b10, 32'h55555555}) begin
      n_fail++; $display("FAIL divu_same_dst: got %h expected %h", {cyc[7:0], wr_en, wr2_en, wr_data}, {8'd34, 2'b10, 32'h55555555});
    end
    n_assert++;
    if ({flag_we, flags[2:0]} !== 7'b0111_000) begin
      n_fail++; $display("FAIL divu_flags: got %b expected %b", {flag_we, flags[2:0]}, 7'b0111_000);
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero;
    int cyc;
    drive(3'd7, 32'd0, 32'd9, 1'b0, 5'd2, 5'd3);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    n_assert++;
    if (cyc !== 34) begin
      n_fail++; $display("FAIL dz_latency: got %0d expected %0d", cyc, 34);
    end
    n_assert++;
    if ({wr_en, wr2_en, flag_we, flags[2]} !== 7'b00_0100_1) begin
      n_fail++; $display("FAIL dz_result: got %b expected %b", {wr_en, wr2_en, flag_we, flags[2]}, 7'b00_0100_1);
    end
    @(negedge clk);
  endtask

  task automatic test_div_overflow;
    int cyc;
    drive(3'd6, 32'hFFFFFFFF, 32'h80000000, 1'b0, 5'd7, 5'd8);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    n_assert++;
    if ({cyc[7:0], wr_en, wr2_en, wr_data, wr2_data} !== {8'd34, 2'b11, 32'h80000000, 32'h0}) begin
      n_fail++; $display("FAIL ovf_data: got %h expected %h", {cyc[7:0], wr_en, wr2_en, wr_data, wr2_data}, {8'd34, 2'b11, 32'h80000000, 32'h0});
    end
    n_assert++;
    if ({flag_we, flags[2:0]} !== 7'b0111_110) begin
      n_fail++; $display("FAIL ovf_flags: got %b expected %b", {flag_we, flags[2:0]}, 7'b0111_110);
    end
    @(negedge clk);
  endtask

  task automatic test_abort;
    logic seen;
    drive(3'd7, 32'd3, 32'd100, 1'b0, 5'd12, 5'd13);
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    repeat (9) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    n_assert++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL abort_ready: got %b expected %b", {in_ready, out_valid}, 2'b10);
    end
    rst = 1'b0;
    repeat (40) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    n_assert++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_valid: got %b expected %b", seen, 1'b0);
    end
    drive(3'd0, 32'd1, 32'd2, 1'b0, 5'd0, 5'd0);
    @(negedge clk);
    in_valid = 1'b0;
    n_assert++;
    if ({out_valid, wr_en, wr_data} !== {2'b10, 32'd3}) begin
      n_fail++; $display("FAIL r0_add: got %h expected %h", {out_valid, wr_en, wr_data}, {2'b10, 32'd3});
    end
    n_assert++;
    if ({flag_we, flags} !== 8'b1111_0000) begin
      n_fail++; $display("FAIL r0_flags: got %b expected %b", {flag_we, flags}, 8'b1111_0000);
    end
    @(negedge clk);
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    test_reset;
    test_add;
    test_back_to_back;
    test_div_signed;
    test_divu;
    test_div_zero;
    test_div_overflow;
    test_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
